traffic_phase_ctrl: RTL and testbench
=====================================

// Module: traffic_phase_ctrl
// PURPOSE
//  Parametrised demand-driven traffic-light controller for one main/side intersection with pedestrian phase.
//  Successor to the fixed 6-bit-counter controller: programmable phase durations, sensor-weighted green extension,
//  a latched pedestrian request with a dedicated all-red walk phase. Sits at the top of the traffic datapath.
// PARAMETERS
//  CNT_W     6   phase-elapsed counter width; must hold GREEN_MAX-1 (elaboration assertion)
//  SENSOR_W  3   width of each traffic-density input
//  GREEN_MIN 20  minimum green cycles for either road
//  GREEN_MAX 48  maximum green cycles (forced change if the other road/ped is waiting)
//  YELLOW_T  4   yellow cycles
//  ALLRED_T  2   all-red clearance cycles
//  PED_T     10  pedestrian walk cycles
//  DEMAND_TH 2   side density at/above which side demand ends main green after GREEN_MIN
//  FLASH_HALF 8  half-period of night flash (used only with NIGHT_FLASH_EN)
// PORTS
//  clk            in  1         system clock
//  reset          in  1         synchronous, active-high
//  pedButton      in  1         pedestrian request, level-sampled each cycle
//  mainTrafficIn  in  SENSOR_W  main-road density (0 = empty)
//  sideTrafficIn  in  SENSOR_W  side-road density (0 = empty)
//  nightMode      in  1         only when NIGHT_FLASH_EN defined
//  MG,MY,MR       out 1         main green/yellow/red
//  SG,SY,SR       out 1         side green/yellow/red
//  pedLight       out 1         walk indicator
//  phaseCount     out CNT_W     elapsed cycles in current state (debug)
// BEHAVIOUR
//  - One clock, clk; reset synchronous active-high. Reset: state MAIN_GREEN, elapsed=0, pedReq=0; MG=SR=1, all else 0.
//  - Moore outputs decoded from state reg; exactly one main and one side lamp lit in every state.
//  - elapsed clears on every state change, else increments, saturating at GREEN_MAX-1.
//  - pedReq set when pedButton=1; cleared on the cycle PED_WALK is entered (clear wins over simultaneous press).
//  - MAIN_GREEN (MG,SR): exit to MAIN_YELLOW when elapsed>=GREEN_MIN-1 and (side>=DEMAND_TH or pedReq),
//    or elapsed==GREEN_MAX-1 and (side!=0 or pedReq). No demand: holds indefinitely.
//  - MAIN_YELLOW (MY,SR) YELLOW_T cycles -> ALL_RED_1 (MR,SR) ALLRED_T cycles -> PED_WALK if pedReq else SIDE_GREEN.
//  - SIDE_GREEN (MR,SG): exit when elapsed>=GREEN_MIN-1 and (side==0 or main>side or pedReq),
//    or elapsed==GREEN_MAX-1 unconditionally.
//  - SIDE_YELLOW (MR,SY) YELLOW_T -> ALL_RED_2 (MR,SR) ALLRED_T -> PED_WALK if pedReq else MAIN_GREEN.
//  - PED_WALK (MR,SR,pedLight) PED_T cycles -> SIDE_GREEN if side!=0 and entered from ALL_RED_1, else MAIN_GREEN.
//  - Durations counted from state entry cycle (elapsed=0); exit at edge where elapsed==T-1.
//  - Density compare unsigned, SENSOR_W bits. Reset mid-phase: MAIN_GREEN on next cycle, pedReq lost.
// CONFIGURATION
//  NIGHT_FLASH_EN defined: adds nightMode port and FLASH state. nightMode=1 sampled in MAIN_GREEN forces exit
//   (ignoring GREEN_MIN) via MAIN_YELLOW/ALL_RED_1 into FLASH; in FLASH MY and SR toggle together every
//   FLASH_HALF cycles (MY starts 1), all other lamps 0, pedReq still latches. nightMode=0 -> ALL_RED_2 -> normal.
//  Undefined: no port, no FLASH state, FLASH_HALF unused.
// STRUCTURE
//  traffic_pkg: phase_e enum (MAIN_GREEN..PED_WALK, FLASH), lamp-vector struct, density compare function.
//  Sub-module phase_timer: CNT_W saturating elapsed counter with sync clear, replaces fixed six-bit counter.
// TESTING (defaults; cycle 0 = first cycle after reset deasserts)
//  1 reset held 3 cycles mid SIDE_GREEN -> MG=SR=1, others 0, phaseCount=0 at cycle 0.
//  2 side=3 constant, ped=0 -> MY cycles 20-23, MR+SR 24-25, SG from 26; side=0 at 30 -> SY at cycle 46.
//  3 side=0, main=5, no ped -> MG stays 1 for 200 cycles, phaseCount saturates at 47.
//  4 side=0, pedButton pulse cycle 5 -> MY 20-23, all red 24-25, pedLight 26-35, MG at 36.
//  5 side=1 (<DEMAND_TH) -> MY at cycle 48; press ped on PED_WALK entry cycle -> no second walk.
//  6 NIGHT_FLASH_EN: nightMode=1 at cycle 3 -> MY 4-7, all red 8-9, FLASH from 10 toggling every 8.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase controller: phase encoding,
// lamp bundle and unsigned density compares. Optional macro: NIGHT_FLASH_EN.
package traffic_pkg;

    localparam int DENS_W = 8;

    typedef enum logic [2:0] {
        MAIN_GREEN,
        MAIN_YELLOW,
        ALL_RED_1,
        SIDE_GREEN,
        SIDE_YELLOW,
        ALL_RED_2,
        PED_WALK
`ifdef NIGHT_FLASH_EN
        , FLASH
`endif
    } phase_e;

    typedef struct packed {
        logic mg;
        logic my;
        logic mr;
        logic sg;
        logic sy;
        logic sr;
        logic walk;
    } lamp_t;

    function automatic logic dens_gt(input logic [DENS_W-1:0] a,
                                     input logic [DENS_W-1:0] b);
        return a > b;
    endfunction

    function automatic logic dens_ge(input logic [DENS_W-1:0] a,
                                     input logic [DENS_W-1:0] b);
        return a >= b;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Saturating elapsed-cycle counter with synchronous clear.
// Counts up from 0 and holds at SAT until cleared.
module phase_timer #(
    parameter int CNT_W = 6,
    parameter logic [CNT_W-1:0] SAT = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // count up, hold at saturation, clear on reset or request
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (count != SAT) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Demand-driven main/side traffic controller with latched pedestrian walk.
// Optional macro: NIGHT_FLASH_EN adds nightMode and a flashing-yellow state.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 6,
    parameter int SENSOR_W   = 3,
    parameter int GREEN_MIN  = 20,
    parameter int GREEN_MAX  = 48,
    parameter int YELLOW_T   = 4,
    parameter int ALLRED_T   = 2,
    parameter int PED_T      = 10,
    parameter int DEMAND_TH  = 2,
    parameter int FLASH_HALF = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pedButton,
    input  logic [SENSOR_W-1:0] mainTrafficIn,
    input  logic [SENSOR_W-1:0] sideTrafficIn,
`ifdef NIGHT_FLASH_EN
    input  logic                nightMode,
`endif
    output logic                MG,
    output logic                MY,
    output logic                MR,
    output logic                SG,
    output logic                SY,
    output logic                SR,
    output logic                pedLight,
    output logic [CNT_W-1:0]    phaseCount
);

    if (GREEN_MAX - 1 >= (1 << CNT_W)) begin : g_cnt_chk
        $error("CNT_W too narrow for GREEN_MAX-1");
    end
    if (SENSOR_W > DENS_W) begin : g_sns_chk
        $error("SENSOR_W wider than density compare");
    end
    if (FLASH_HALF < 1 || FLASH_HALF > GREEN_MAX) begin : g_fl_chk
        $error("FLASH_HALF out of range");
    end

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] PED_M1  = CNT_W'(PED_T - 1);

    phase_e           state;
    phase_e           next;
    logic [CNT_W-1:0] elapsed;
    logic             ped_req;
    logic             from_ar1;
    logic             night_req;
    logic             flash_wrap;
    logic             timer_clr;
    lamp_t            lamp;

    logic side_dem;
    logic side_any;
    logic main_gt;
    logic at_min;
    logic at_max;
    logic entering_walk;

    assign side_dem = dens_ge(DENS_W'(sideTrafficIn), DENS_W'(DEMAND_TH));
    assign side_any = sideTrafficIn != '0;
    assign main_gt  = dens_gt(DENS_W'(mainTrafficIn), DENS_W'(sideTrafficIn));
    assign at_min   = elapsed >= GMIN_M1;
    assign at_max   = elapsed == GMAX_M1;

    assign entering_walk = (next == PED_WALK) && (state != PED_WALK);

`ifdef NIGHT_FLASH_EN
    localparam logic [CNT_W-1:0] FH_M1 = CNT_W'(FLASH_HALF - 1);
    logic flash_on;

    assign night_req  = nightMode;
    assign flash_wrap = (state == FLASH) && (elapsed == FH_M1);

    // flash phase restarts lit on entry, flips each half-period
    always_ff @(posedge clk) begin
        if (reset || state != FLASH) begin
            flash_on <= 1'b1;
        end else if (flash_wrap) begin
            flash_on <= ~flash_on;
        end
    end
`else
    assign night_req  = 1'b0;
    assign flash_wrap = 1'b0;
`endif

    assign timer_clr = (next != state) || flash_wrap;

    phase_timer #(
        .CNT_W (CNT_W),
        .SAT   (GMAX_M1)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .count (elapsed)
    );

    // phase register plus walk bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MAIN_GREEN;
            ped_req  <= 1'b0;
            from_ar1 <= 1'b0;
        end else begin
            state <= next;
            if (entering_walk || (state == PED_WALK && elapsed == '0)) begin
                ped_req <= 1'b0;
            end else if (pedButton) begin
                ped_req <= 1'b1;
            end
            if (entering_walk) begin
                from_ar1 <= (state == ALL_RED_1);
            end
        end
    end

    // next-phase selection
    always_comb begin
        next = state;
        unique case (state)
            MAIN_GREEN: begin
                if (night_req ||
                    (at_min && (side_dem || ped_req)) ||
                    (at_max && (side_any || ped_req))) begin
                    next = MAIN_YELLOW;
                end
            end
            MAIN_YELLOW: begin
                if (elapsed == YEL_M1) next = ALL_RED_1;
            end
            ALL_RED_1: begin
                if (elapsed == AR_M1) begin
`ifdef NIGHT_FLASH_EN
                    if (night_req) next = FLASH;
                    else
`endif
                    if (ped_req) next = PED_WALK;
                    else next = SIDE_GREEN;
                end
            end
            SIDE_GREEN: begin
                if ((at_min && (!side_any || main_gt || ped_req)) ||
                    at_max) begin
                    next = SIDE_YELLOW;
                end
            end
            SIDE_YELLOW: begin
                if (elapsed == YEL_M1) next = ALL_RED_2;
            end
            ALL_RED_2: begin
                if (elapsed == AR_M1) begin
                    next = ped_req ? PED_WALK : MAIN_GREEN;
                end
            end
            PED_WALK: begin
                if (elapsed == PED_M1) begin
                    next = (side_any && from_ar1) ? SIDE_GREEN : MAIN_GREEN;
                end
            end
`ifdef NIGHT_FLASH_EN
            FLASH: begin
                if (!night_req) next = ALL_RED_2;
            end
`endif
            default: next = MAIN_GREEN;
        endcase
    end

    // Moore lamp decode from the phase register
    always_comb begin
        lamp = '0;
        unique case (state)
            MAIN_GREEN:  begin lamp.mg = 1'b1; lamp.sr = 1'b1; end
            MAIN_YELLOW: begin lamp.my = 1'b1; lamp.sr = 1'b1; end
            ALL_RED_1:   begin lamp.mr = 1'b1; lamp.sr = 1'b1; end
            SIDE_GREEN:  begin lamp.mr = 1'b1; lamp.sg = 1'b1; end
            SIDE_YELLOW: begin lamp.mr = 1'b1; lamp.sy = 1'b1; end
            ALL_RED_2:   begin lamp.mr = 1'b1; lamp.sr = 1'b1; end
            PED_WALK: begin
                lamp.mr   = 1'b1;
                lamp.sr   = 1'b1;
                lamp.walk = 1'b1;
            end
`ifdef NIGHT_FLASH_EN
            FLASH: begin
                lamp.my = flash_on;
                lamp.sr = flash_on;
            end
`endif
            default:     begin lamp.mg = 1'b1; lamp.sr = 1'b1; end
        endcase
    end

    assign MG         = lamp.mg;
    assign MY         = lamp.my;
    assign MR         = lamp.mr;
    assign SG         = lamp.sg;
    assign SY         = lamp.sy;
    assign SR         = lamp.sr;
    assign pedLight   = lamp.walk;
    assign phaseCount = elapsed;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl; cycle 0 is the first cycle
// after reset deasserts. Optional macro: NIGHT_FLASH_EN.
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       pedButton;
    logic [2:0] mainTrafficIn;
    logic [2:0] sideTrafficIn;
    logic       nightMode;
    logic       MG, MY, MR, SG, SY, SR, pedLight;
    logic [5:0] phaseCount;
    logic [6:0] lamps;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    localparam logic [6:0] L_MG_SR = 7'b1000010;
    localparam logic [6:0] L_MY_SR = 7'b0100010;
    localparam logic [6:0] L_MR_SR = 7'b0010010;
    localparam logic [6:0] L_MR_SG = 7'b0011000;
    localparam logic [6:0] L_MR_SY = 7'b0010100;
    localparam logic [6:0] L_WALK  = 7'b0010011;
    localparam logic [6:0] L_OFF   = 7'b0000000;

    assign lamps = {MG, MY, MR, SG, SY, SR, pedLight};

    traffic_phase_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .pedButton     (pedButton),
        .mainTrafficIn (mainTrafficIn),
        .sideTrafficIn (sideTrafficIn),
`ifdef NIGHT_FLASH_EN
        .nightMode     (nightMode),
`endif
        .MG            (MG),
        .MY            (MY),
        .MR            (MR),
        .SG            (SG),
        .SY            (SY),
        .SR            (SR),
        .pedLight      (pedLight),
        .phaseCount    (phaseCount)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed=%0h expected=%0h",
                   tag, cyc, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        pedButton = 1'b0;
        mainTrafficIn = 3'd0;
        sideTrafficIn = 3'd3;
        nightMode = 1'b0;
        @(negedge clk);
        do_reset(2);

        // reset held mid side green
        run_to(28);
        chk("t1_sg_before_rst", 32'(lamps), 32'(L_MR_SG));
        do_reset(3);
        chk("t1_rst_lamps", 32'(lamps), 32'(L_MG_SR));
        chk("t1_rst_count", 32'(phaseCount), 32'd0);

        // side demand = 3
        run_to(19);
        chk("t2_mg_19", 32'(lamps), 32'(L_MG_SR));
        run_to(20);
        chk("t2_my_20", 32'(lamps), 32'(L_MY_SR));
        run_to(23);
        chk("t2_my_23", 32'(lamps), 32'(L_MY_SR));
        run_to(24);
        chk("t2_ar_24", 32'(lamps), 32'(L_MR_SR));
        run_to(25);
        chk("t2_ar_25", 32'(lamps), 32'(L_MR_SR));
        run_to(26);
        chk("t2_sg_26", 32'(lamps), 32'(L_MR_SG));
        chk("t2_cnt_26", 32'(phaseCount), 32'd0);
        run_to(30);
        sideTrafficIn = 3'd0;
        run_to(45);
        chk("t2_sg_45", 32'(lamps), 32'(L_MR_SG));
        chk("t2_cnt_45", 32'(phaseCount), 32'd19);
        run_to(46);
        chk("t2_sy_46", 32'(lamps), 32'(L_MR_SY));
        run_to(50);
        chk("t2_ar2_50", 32'(lamps), 32'(L_MR_SR));
        run_to(52);
        chk("t2_mg_52", 32'(lamps), 32'(L_MG_SR));

        // no side demand, main busy: green holds, counter saturates
        mainTrafficIn = 3'd5;
        run_to(98);
        chk("t3_cnt_46", 32'(phaseCount), 32'd46);
        run_to(99);
        chk("t3_cnt_47", 32'(phaseCount), 32'd47);
        run_to(252);
        chk("t3_mg_hold", 32'(lamps), 32'(L_MG_SR));
        chk("t3_cnt_sat", 32'(phaseCount), 32'd47);

        // pedestrian pulse with empty side road
        mainTrafficIn = 3'd0;
        sideTrafficIn = 3'd0;
        do_reset(2);
        run_to(5);
        pedButton = 1'b1;
        run_to(6);
        pedButton = 1'b0;
        run_to(19);
        chk("t4_mg_19", 32'(lamps), 32'(L_MG_SR));
        run_to(20);
        chk("t4_my_20", 32'(lamps), 32'(L_MY_SR));
        run_to(24);
        chk("t4_ar_24", 32'(lamps), 32'(L_MR_SR));
        run_to(26);
        chk("t4_walk_26", 32'(lamps), 32'(L_WALK));
        run_to(35);
        chk("t4_walk_35", 32'(lamps), 32'(L_WALK));
        run_to(36);
        chk("t4_mg_36", 32'(lamps), 32'(L_MG_SR));

        // weak side demand forces change only at GREEN_MAX
        sideTrafficIn = 3'd1;
        do_reset(2);
        run_to(47);
        chk("t5_mg_47", 32'(lamps), 32'(L_MG_SR));
        run_to(48);
        chk("t5_my_48", 32'(lamps), 32'(L_MY_SR));
        run_to(54);
        chk("t5_sg_54", 32'(lamps), 32'(L_MR_SG));
        run_to(60);
        pedButton = 1'b1;
        run_to(61);
        pedButton = 1'b0;
        run_to(73);
        chk("t5_sg_73", 32'(lamps), 32'(L_MR_SG));
        run_to(74);
        chk("t5_sy_74", 32'(lamps), 32'(L_MR_SY));
        run_to(80);
        chk("t5_walk_80", 32'(lamps), 32'(L_WALK));
        pedButton = 1'b1;
        run_to(81);
        pedButton = 1'b0;
        run_to(89);
        chk("t5_walk_89", 32'(lamps), 32'(L_WALK));
        run_to(90);
        chk("t5_mg_90", 32'(lamps), 32'(L_MG_SR));
        run_to(110);
        chk("t5_no_rewalk", 32'(lamps), 32'(L_MG_SR));
        run_to(137);
        chk("t5_mg_137", 32'(lamps), 32'(L_MG_SR));
        run_to(138);
        chk("t5_my_138", 32'(lamps), 32'(L_MY_SR));

`ifdef NIGHT_FLASH_EN
        // night flash entry and exit
        sideTrafficIn = 3'd0;
        do_reset(2);
        run_to(3);
        nightMode = 1'b1;
        run_to(4);
        chk("t6_my_4", 32'(lamps), 32'(L_MY_SR));
        run_to(7);
        chk("t6_my_7", 32'(lamps), 32'(L_MY_SR));
        run_to(8);
        chk("t6_ar_8", 32'(lamps), 32'(L_MR_SR));
        run_to(10);
        chk("t6_fl_on_10", 32'(lamps), 32'(L_MY_SR));
        run_to(17);
        chk("t6_fl_on_17", 32'(lamps), 32'(L_MY_SR));
        run_to(18);
        chk("t6_fl_off_18", 32'(lamps), 32'(L_OFF));
        run_to(25);
        chk("t6_fl_off_25", 32'(lamps), 32'(L_OFF));
        run_to(26);
        chk("t6_fl_on_26", 32'(lamps), 32'(L_MY_SR));
        nightMode = 1'b0;
        run_to(27);
        chk("t6_ar2_27", 32'(lamps), 32'(L_MR_SR));
        run_to(29);
        chk("t6_mg_29", 32'(lamps), 32'(L_MG_SR));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
